s2p_frame_arbiter: RTL and testbench
====================================

// Module: s2p_frame_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer that shares one 6-bit serial-to-parallel converter
//   between N serial requesters. Grants one requester per frame and holds the grant until
//   FRAME_BITS bits are accepted. Steers the granted bit stream onto the converter input
//   and tags each completed frame with its source ID. Aborts and flushes on stalled frames.
// PARAMETERS
//   N          3   number of requesters, >=2; IDW = max(1,$clog2(N))
//   FRAME_BITS 6   bits per frame; must equal converter width
//   TIMEOUT    8   max consecutive SEND cycles with no accepted bit; 0 = timeout disabled
// PORTS
//   clk          in   1    single clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   req          in   N    requester i has a frame to send; level, held until granted
//   valid_a      in   N    serial bit valid per requester
//   data_a       in   N    serial bit per requester, LSB of frame first
//   ready_a      out  N    one-hot grant; requester may drive bits only while set
//   conv_valid   out  1    bit valid to converter
//   conv_data    out  1    bit to converter
//   conv_flush   out  1    1-cycle pulse: clear converter partial frame
//   frame_done   out  1    1-cycle pulse: frame of FRAME_BITS bits completed
//   frame_src    out  IDW  source ID of completed/aborted frame; valid with done/abort
//   frame_abort  out  1    1-cycle pulse: granted frame timed out
//   busy         out  1    high in SEND
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, ready_a=0, frame_done=0, frame_abort=0,
//     conv_flush=0, frame_src=0, bit_cnt=0, idle_cnt=0, last_winner=N-1 (req 0 wins first).
//     conv_valid/conv_data=0 in IDLE.
//   - FSM IDLE: if |req, winner = first set index scanning last_winner+1 .. last_winner+N
//     (mod N); on clock edge grant<=winner, last_winner<=winner, state<=SEND.
//     ready_a[winner] rises the cycle after req is sampled. No req: stay IDLE.
//   - FSM SEND: ready_a = onehot(grant) (registered). Bit accepted when valid_a[grant]=1.
//     conv_valid = valid_a[grant]; conv_data = data_a[grant]; combinational, zero latency.
//     valid_a/data_a of non-granted requesters ignored; req of granted ignored mid-frame.
//   - bit_cnt increments per accepted bit; on accepting bit FRAME_BITS-1 (last): bit_cnt<=0,
//     state<=IDLE, ready_a drops at that edge, frame_done=1 and frame_src=grant registered
//     on that same edge (visible next cycle, aligned with converter valid_b).
//   - Back-to-back: exactly one IDLE cycle between frames (last bit cycle -> IDLE -> SEND).
//   - Timeout (TIMEOUT>0): idle_cnt counts consecutive SEND cycles with no accepted bit,
//     cleared on any accepted bit. Edge where idle_cnt reaches TIMEOUT: state<=IDLE,
//     bit_cnt<=0, frame_abort=1, conv_flush=1, frame_src=grant (pulses next cycle);
//     frame_done not asserted; last_winner already advanced (no retry priority).
//   - frame_done and frame_abort never asserted together; each exactly 1 cycle.
//   - Reset mid-frame: partial frame discarded, no done/abort pulse; integration ties
//     rst_n to converter so both restart together.
//   - Winner scan, ID math wrap mod N; for N not power of 2 IDs >= N never produced.
// TESTING (N=3, FRAME_BITS=6, TIMEOUT=4)
//   1 Reset held 3 cycles, req=111 -> all outputs 0 during reset; after release ready_a=001
//     one cycle after req sampled; busy=1.
//   2 Only req[1]; stream 110011 LSB-first, valid every cycle -> conv_data 1,1,0,0,1,1 on 6
//     consecutive conv_valid cycles; next cycle frame_done=1, frame_src=1; ready_a=000.
//   3 req=111 held, all stream continuously -> grant order 0,1,2,0; one idle cycle between
//     frames; frame_src sequence 0,1,2,0.
//   4 Granted requester inserts random valid_a bubbles (<4 long) -> frame_done only after
//     6 accepted bits; converter output matches golden shift register.
//   5 Requester 2 sends 3 bits then stops -> 4 cycles later frame_abort=1, conv_flush=1,
//     frame_src=2, no frame_done; next grant goes to requester 0 if requesting.
//   6 Assert rst_n=0 after 3 bits of a frame -> ready_a=0 immediately; after release req=111
//     grants requester 0 first; no done/abort pulse emitted.

Source files
------------

// File: rtl/s2p_frame_arbiter.sv
// s2p_frame_arbiter: round-robin sequencer that lends one serial-to-parallel
// converter to N serial requesters, one whole frame at a time, tags each
// finished frame with its source and aborts frames that stall too long.
module s2p_frame_arbiter #(
   parameter int N          = 3,
   parameter int FRAME_BITS = 6,
   parameter int TIMEOUT    = 8,
   localparam int IDW       = ($clog2(N) > 1) ? $clog2(N) : 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [N-1:0]   i_req,
   input  logic [N-1:0]   i_valid_a,
   input  logic [N-1:0]   i_data_a,
   output logic [N-1:0]   o_ready_a,
   output logic           o_conv_valid,
   output logic           o_conv_data,
   output logic           o_conv_flush,
   output logic           o_frame_done,
   output logic [IDW-1:0] o_frame_src,
   output logic           o_frame_abort,
   output logic           o_busy
);

   localparam int BCW = ($clog2(FRAME_BITS) > 1) ? $clog2(FRAME_BITS) : 1;
   localparam int ICW = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t         r_state;
   logic [IDW-1:0] r_grant;
   logic [IDW-1:0] r_lastWinner;
   logic [BCW-1:0] r_bitCnt;
   logic [ICW-1:0] r_idleCnt;
   logic [N-1:0]   r_ready;
   logic           r_frameDone;
   logic           r_frameAbort;
   logic           r_convFlush;
   logic [IDW-1:0] r_frameSrc;

   logic [IDW-1:0] w_winner;
   logic [IDW-1:0] w_cand;
   logic           w_found;
   logic           w_send;
   logic           w_accept;
   logic           w_lastBit;
   logic           w_timeout;

   // Round-robin pick: first requester after the previous winner, wrapping mod N
   always_comb begin
      w_winner = r_lastWinner;
      w_found  = 1'b0;
      w_cand   = r_lastWinner;
      for (int k = 1; k <= N; k++) begin
         w_cand = IDW'((int'(r_lastWinner) + k) % N);
         if (!w_found && i_req[w_cand]) begin
            w_found  = 1'b1;
            w_winner = w_cand;
         end
      end
   end

   assign w_send    = (r_state == SEND);
   assign w_accept  = w_send && i_valid_a[r_grant];
   assign w_lastBit = (r_bitCnt == BCW'(FRAME_BITS - 1));
   assign w_timeout = (TIMEOUT != 0) && (r_idleCnt == ICW'(TIMEOUT - 1));

   // Grant sequencing, frame bit counting, stall timeout and the status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_grant      <= '0;
         r_lastWinner <= IDW'(N - 1);
         r_bitCnt     <= '0;
         r_idleCnt    <= '0;
         r_ready      <= '0;
         r_frameDone  <= 1'b0;
         r_frameAbort <= 1'b0;
         r_convFlush  <= 1'b0;
         r_frameSrc   <= '0;
      end else begin
         r_frameDone  <= 1'b0;
         r_frameAbort <= 1'b0;
         r_convFlush  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_grant      <= w_winner;
                  r_lastWinner <= w_winner;
                  r_ready      <= N'(1) << w_winner;
                  r_bitCnt     <= '0;
                  r_idleCnt    <= '0;
                  r_state      <= SEND;
               end
            end
            SEND: begin
               if (w_accept) begin
                  r_idleCnt <= '0;
                  if (w_lastBit) begin
                     r_bitCnt    <= '0;
                     r_ready     <= '0;
                     r_frameDone <= 1'b1;
                     r_frameSrc  <= r_grant;
                     r_state     <= IDLE;
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                  end
               end else if (w_timeout) begin
                  r_idleCnt    <= '0;
                  r_bitCnt     <= '0;
                  r_ready      <= '0;
                  r_frameAbort <= 1'b1;
                  r_convFlush  <= 1'b1;
                  r_frameSrc   <= r_grant;
                  r_state      <= IDLE;
               end else if (TIMEOUT != 0) begin
                  r_idleCnt <= r_idleCnt + 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_ready_a     = r_ready;
   assign o_conv_valid  = w_accept;
   assign o_conv_data   = w_send && i_data_a[r_grant];
   assign o_conv_flush  = r_convFlush;
   assign o_frame_done  = r_frameDone;
   assign o_frame_src   = r_frameSrc;
   assign o_frame_abort = r_frameAbort;
   assign o_busy        = w_send;

endmodule

// File: tb/tb_s2p_frame_arbiter.sv
// tb_s2p_frame_arbiter: directed bench with a scoreboard of expected converter
// bits, completed frames and aborted frames.
module tb_s2p_frame_arbiter;

   localparam int N   = 3;
   localparam int FB  = 6;
   localparam int TO  = 4;
   localparam int IDW = 2;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [N-1:0]   validA;
   logic [N-1:0]   dataA;
   logic [N-1:0]   readyA;
   logic           convValid;
   logic           convData;
   logic           convFlush;
   logic           frameDone;
   logic [IDW-1:0] frameSrc;
   logic           frameAbort;
   logic           busy;

   typedef struct {
      int            id;
      logic [FB-1:0] bits;
   } frame_t;

   frame_t frameQ[$];
   logic   bitQ[$];
   int     abortQ[$];

   int nCompared   = 0;
   int nMismatched = 0;

   s2p_frame_arbiter #(.N(N), .FRAME_BITS(FB), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req         (req),
      .i_valid_a     (validA),
      .i_data_a      (dataA),
      .o_ready_a     (readyA),
      .o_conv_valid  (convValid),
      .o_conv_data   (convData),
      .o_conv_flush  (convFlush),
      .o_frame_done  (frameDone),
      .o_frame_src   (frameSrc),
      .o_frame_abort (frameAbort),
      .o_busy        (busy)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      nCompared++;
      assert (observed === expected)
      else begin
         nMismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Waits (bounded) for any grant; returns the number of cycles waited
   task automatic waitReady(output int gap);
      gap = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         gap++;
         if (readyA != '0) break;
      end
   endtask

   // Waits for the grant, then streams one frame LSB-first with optional bubbles
   task automatic applyStimulus(input int id, input logic [FB-1:0] bits, input int maxBubble,
                                input bit keepReq, input int expGap);
      int     gap;
      frame_t f;
      waitReady(gap);
      checkOutput("grant_onehot", 32'(readyA), 32'(1) << id);
      checkOutput("grant_latency", 32'(gap), 32'(expGap));
      checkOutput("busy_in_send", 32'(busy), 32'd1);
      if (readyA[id] !== 1'b1) return;
      if (!keepReq) req[id] = 1'b0;
      f.id   = id;
      f.bits = bits;
      frameQ.push_back(f);
      for (int b = 0; b < FB; b++) begin
         int nb;
         nb = (maxBubble > 0) ? int'($urandom_range(maxBubble, 0)) : 0;
         repeat (nb) begin
            validA[id] = 1'b0;
            @(posedge clk);
            #1;
         end
         validA[id] = 1'b1;
         dataA[id]  = bits[b];
         bitQ.push_back(bits[b]);
         @(posedge clk);
         #1;
      end
      validA[id] = 1'b0;
      dataA[id]  = 1'b0;
      checkOutput("ready_drop", 32'(readyA), 32'd0);
      checkOutput("busy_idle", 32'(busy), 32'd0);
   endtask

   // Converter-side monitor: pops expected bits/frames/aborts as the DUT emits them
   initial begin
      logic [FB-1:0] shReg;
      int            shCnt;
      logic          expBit;
      frame_t        f;
      int            aid;
      shReg = '0;
      shCnt = 0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            shReg = '0;
            shCnt = 0;
         end else begin
            checkOutput("flush_eq_abort", 32'(convFlush), 32'(frameAbort));
            checkOutput("done_abort_excl", 32'(frameDone & frameAbort), 32'd0);
            if (frameDone) begin
               if (frameQ.size() == 0) begin
                  checkOutput("spurious_done", 32'(frameDone), 32'd0);
               end else begin
                  f = frameQ.pop_front();
                  checkOutput("done_src", 32'(frameSrc), 32'(f.id));
                  checkOutput("done_bits", 32'(shReg), 32'(f.bits));
                  checkOutput("done_count", 32'(shCnt), 32'(FB));
               end
               shCnt = 0;
            end
            if (frameAbort) begin
               if (abortQ.size() == 0) begin
                  checkOutput("spurious_abort", 32'(frameAbort), 32'd0);
               end else begin
                  aid = abortQ.pop_front();
                  checkOutput("abort_src", 32'(frameSrc), 32'(aid));
               end
               shCnt = 0;
            end
            if (convValid) begin
               if (bitQ.size() == 0) begin
                  checkOutput("spurious_bit", 32'(convValid), 32'd0);
               end else begin
                  expBit = bitQ.pop_front();
                  checkOutput("conv_bit", 32'(convData), 32'(expBit));
                  shReg = {convData, shReg[FB-1:1]};
                  shCnt++;
               end
            end
         end
      end
   end

   // Hard time limit so a stuck design can never hang the run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of scenarios
   initial begin
      logic [FB-1:0] bits;
      rst_n  = 1'b0;
      req    = 3'b111;
      validA = '0;
      dataA  = '0;

      // Reset held three cycles with every requester asking
      repeat (3) begin
         @(posedge clk);
         #1;
         checkOutput("rst_ready", 32'(readyA), 32'd0);
         checkOutput("rst_done", 32'(frameDone), 32'd0);
         checkOutput("rst_abort", 32'(frameAbort), 32'd0);
         checkOutput("rst_flush", 32'(convFlush), 32'd0);
         checkOutput("rst_src", 32'(frameSrc), 32'd0);
         checkOutput("rst_conv", 32'({convValid, convData}), 32'd0);
         checkOutput("rst_busy", 32'(busy), 32'd0);
      end
      rst_n = 1'b1;
      applyStimulus(0, 6'b101101, 0, 1'b0, 1);
      req = '0;

      // Single requester 1 sending 110011 (LSB first: 1,1,0,0,1,1)
      @(posedge clk);
      #1;
      req = 3'b010;
      bits = 6'b110011;
      applyStimulus(1, bits, 0, 1'b0, 1);

      // Requester 1 with random valid bubbles of at most 3 cycles
      req = 3'b010;
      applyStimulus(1, 6'($urandom), 3, 1'b0, 1);
      req = 3'b010;
      applyStimulus(1, 6'($urandom), 3, 1'b0, 1);

      // Requester 2 stalls after three bits and is aborted
      req = 3'b100;
      begin
         int gap;
         waitReady(gap);
         checkOutput("t5_grant", 32'(readyA), 32'b100);
         checkOutput("t5_latency", 32'(gap), 32'd1);
      end
      req  = 3'b001;
      bits = 6'b000101;
      for (int b = 0; b < 3; b++) begin
         validA[2] = 1'b1;
         dataA[2]  = bits[b];
         bitQ.push_back(bits[b]);
         @(posedge clk);
         #1;
      end
      validA[2] = 1'b0;
      dataA[2]  = 1'b0;
      abortQ.push_back(2);
      for (int i = 0; i < TO; i++) begin
         checkOutput("t5_still_busy", 32'(busy), 32'd1);
         checkOutput("t5_no_early_abort", 32'(frameAbort), 32'd0);
         @(posedge clk);
         #1;
      end
      checkOutput("t5_abort", 32'(frameAbort), 32'd1);
      checkOutput("t5_flush", 32'(convFlush), 32'd1);
      checkOutput("t5_src", 32'(frameSrc), 32'd2);
      checkOutput("t5_no_done", 32'(frameDone), 32'd0);
      checkOutput("t5_idle", 32'(busy), 32'd0);
      checkOutput("t5_ready", 32'(readyA), 32'd0);

      // All requesters streaming back-to-back: rotation 0,1,2,0
      req = 3'b111;
      applyStimulus(0, 6'($urandom), 0, 1'b1, 1);
      applyStimulus(1, 6'($urandom), 0, 1'b1, 1);
      applyStimulus(2, 6'($urandom), 0, 1'b1, 1);
      applyStimulus(0, 6'($urandom), 0, 1'b1, 1);
      req = '0;

      // Reset in the middle of a frame from requester 2
      @(posedge clk);
      #1;
      req = 3'b100;
      begin
         int gap;
         waitReady(gap);
         checkOutput("t6_grant", 32'(readyA), 32'b100);
      end
      req  = '0;
      bits = 6'b111010;
      for (int b = 0; b < 3; b++) begin
         validA[2] = 1'b1;
         dataA[2]  = bits[b];
         bitQ.push_back(bits[b]);
         @(posedge clk);
         #1;
      end
      validA[2] = 1'b0;
      dataA[2]  = 1'b0;
      rst_n     = 1'b0;
      #1;
      checkOutput("t6_ready_async", 32'(readyA), 32'd0);
      checkOutput("t6_busy_async", 32'(busy), 32'd0);
      checkOutput("t6_conv_async", 32'(convValid), 32'd0);
      checkOutput("t6_no_done", 32'(frameDone), 32'd0);
      checkOutput("t6_no_abort", 32'(frameAbort), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      req   = 3'b111;
      rst_n = 1'b1;
      applyStimulus(0, 6'($urandom), 0, 1'b0, 1);
      req = '0;

      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checkOutput("bitq_drained", 32'(bitQ.size()), 32'd0);
      checkOutput("frameq_drained", 32'(frameQ.size()), 32'd0);
      checkOutput("abortq_drained", 32'(abortQ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
